// File: rtl/dmem_dual_port_arbiter.sv
// dmem_dual_port_arbiter
//   Shares the single data-memory port between the two MEM-stage issue slots
//   of the dual-issue pipeline. A single access goes straight through with no
//   added latency. When both slots access memory in the same cycle, the block
//   serializes them: slot 1 goes first while the front of the pipeline is
//   stalled for one cycle, then slot 2. Conflict stalls are counted in a
//   saturating counter.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | pass-through; a dual request grants slot 1 and raises stall
//   SERVE2 | second half of a conflict: slot 2 is granted and slot 1's load
//          | data is replayed from hold_rd
//
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   *_inst1_Mem / *_inst1       slot-1 enables, address (ALU out), store data
//   *_inst2_Mem / *_inst2       slot-2 enables, address (ALU out), store data
//   mem_rdata                   combinational read data for mem_addr
//   mem_addr/wdata/we/re        data-memory port
//   rdata_inst1 / rdata_inst2   load results toward MEM/WB
//   mem_stall                   freezes the front of the pipeline for one cycle
//   conflict_cnt                saturating count of conflict stalls
module dmem_dual_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadEn_inst1_Mem,
  input  logic              MemWriteEn_inst1_Mem,
  input  logic [DATA_W-1:0] AluOutMem_inst1,
  input  logic [DATA_W-1:0] ReadData2Mem_inst1,
  input  logic              MemReadEn_inst2_Mem,
  input  logic              MemWriteEn_inst2_Mem,
  input  logic [DATA_W-1:0] AluOutMem_inst2,
  input  logic [DATA_W-1:0] ReadData2Mem_inst2,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] rdata_inst1,
  output logic [DATA_W-1:0] rdata_inst2,
  output logic              mem_stall,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SERVE2 = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_next_state;
  logic [DATA_W-1:0] r_hold_rd;
  logic [CNT_W-1:0]  r_conflict_cnt;

  logic w_req1;
  logic w_req2;
  logic w_conflict;

  assign w_req1     = MemReadEn_inst1_Mem | MemWriteEn_inst1_Mem;
  assign w_req2     = MemReadEn_inst2_Mem | MemWriteEn_inst2_Mem;
  assign w_conflict = (r_state == IDLE) & w_req1 & w_req2;

  // Only the word-address bits of the ALU result reach the memory.
  logic w_unused;
  assign w_unused = ^{AluOutMem_inst1[DATA_W-1:ADDR_W],
                      AluOutMem_inst2[DATA_W-1:ADDR_W]};

  // The memory port is forced quiet while reset is held, even if the
  // pipeline registers upstream still present requests.
  always_comb begin
    w_next_state = r_state;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_stall    = 1'b0;
    if (reset) begin
      case (r_state)
        IDLE: begin
          if (w_req1) begin
            mem_addr  = AluOutMem_inst1[ADDR_W-1:0];
            mem_wdata = ReadData2Mem_inst1;
            mem_we    = MemWriteEn_inst1_Mem;
            // read+write in one slot behaves as a write
            mem_re    = MemReadEn_inst1_Mem & ~MemWriteEn_inst1_Mem;
            if (w_req2) begin
              mem_stall    = 1'b1;
              w_next_state = SERVE2;
            end
          end else if (w_req2) begin
            mem_addr  = AluOutMem_inst2[ADDR_W-1:0];
            mem_wdata = ReadData2Mem_inst2;
            mem_we    = MemWriteEn_inst2_Mem;
            mem_re    = MemReadEn_inst2_Mem & ~MemWriteEn_inst2_Mem;
          end
        end
        SERVE2: begin
          // Never stalls here, so a conflicting pair costs at most one cycle.
          if (w_req2) begin
            mem_addr  = AluOutMem_inst2[ADDR_W-1:0];
            mem_wdata = ReadData2Mem_inst2;
            mem_we    = MemWriteEn_inst2_Mem;
            mem_re    = MemReadEn_inst2_Mem & ~MemWriteEn_inst2_Mem;
          end
          w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_hold_rd      <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_conflict) begin
        // slot 1's load result must survive while slot 2 owns the port
        r_hold_rd <= mem_rdata;
        if (r_conflict_cnt != {CNT_W{1'b1}}) begin
          r_conflict_cnt <= r_conflict_cnt + 1'b1;
        end
      end
    end
  end

  assign rdata_inst1  = (r_state == SERVE2) ? r_hold_rd : mem_rdata;
  assign rdata_inst2  = mem_rdata;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_dmem_dual_port_arbiter.sv
// Directed bench for dmem_dual_port_arbiter with a behavioural data memory.
// A second instance with a 2-bit counter shares all inputs so counter
// saturation can be reached in a few requests.
module tb_dmem_dual_port_arbiter;

  logic        clk;
  logic        reset;
  logic        re1, we1, re2, we2;
  logic [31:0] a1, d1, a2, d2;
  logic [31:0] mem_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we, mem_re, mem_stall;
  logic [31:0] rdata1, rdata2;
  logic [15:0] cnt;

  logic [7:0]  s_addr;
  logic [31:0] s_wdata, s_rd1, s_rd2;
  logic        s_we, s_re, s_stall;
  logic [1:0]  s_cnt;

  logic [31:0] mem [256];
  logic        pl_we;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  int total;
  int bad;

  dmem_dual_port_arbiter dut (
    .clk(clk), .reset(reset),
    .MemReadEn_inst1_Mem(re1), .MemWriteEn_inst1_Mem(we1),
    .AluOutMem_inst1(a1), .ReadData2Mem_inst1(d1),
    .MemReadEn_inst2_Mem(re2), .MemWriteEn_inst2_Mem(we2),
    .AluOutMem_inst2(a2), .ReadData2Mem_inst2(d2),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re),
    .rdata_inst1(rdata1), .rdata_inst2(rdata2),
    .mem_stall(mem_stall), .conflict_cnt(cnt)
  );

  dmem_dual_port_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .MemReadEn_inst1_Mem(re1), .MemWriteEn_inst1_Mem(we1),
    .AluOutMem_inst1(a1), .ReadData2Mem_inst1(d1),
    .MemReadEn_inst2_Mem(re2), .MemWriteEn_inst2_Mem(we2),
    .AluOutMem_inst2(a2), .ReadData2Mem_inst2(d2),
    .mem_rdata(mem_rdata), .mem_addr(s_addr), .mem_wdata(s_wdata),
    .mem_we(s_we), .mem_re(s_re),
    .rdata_inst1(s_rd1), .rdata_inst2(s_rd2),
    .mem_stall(s_stall), .conflict_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic set_req(input logic r1, input logic w1, input logic [31:0] ad1,
                         input logic [31:0] dd1, input logic r2, input logic w2,
                         input logic [31:0] ad2, input logic [31:0] dd2);
    re1 = r1; we1 = w1; a1 = ad1; d1 = dd1;
    re2 = r2; we2 = w2; a2 = ad2; d2 = dd2;
  endtask

  task automatic preload(input logic [7:0] ad, input logic [31:0] dat);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = ad; pl_data = dat;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    preload(8'h10, 32'hAAAA0001);
    preload(8'h04, 32'h00000011);
    preload(8'h08, 32'h00000022);
    preload(8'h40, 32'h00005555);
    preload(8'h00, 32'hC0DE0000);
    @(negedge clk);
    // requests present while reset is held must not reach the memory
    set_req(1, 0, 32'h04, 0, 0, 1, 32'h08, 32'h99);
    #1;
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
    total++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin bad++; $display("FAIL reset_we_re got=%b%b exp=00", mem_we, mem_re); end
    total++; if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_addr_wdata got=%h/%h exp=00/0", mem_addr, mem_wdata); end
    total++; if (cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
    total++; if (rdata1 !== 32'hC0DE0000 || rdata2 !== 32'hC0DE0000) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=c0de0000", rdata1, rdata2); end
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
  endtask

  task automatic test_single_slot1;
    @(negedge clk);
    set_req(1, 0, 32'hFFFF_FF10, 0, 0, 0, 0, 0);
    #1;
    total++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL s1_re_we got=%b%b exp=10", mem_re, mem_we); end
    total++; if (mem_addr !== 8'h10) begin bad++; $display("FAIL s1_addr got=%h exp=10", mem_addr); end
    total++; if (rdata1 !== 32'hAAAA0001) begin bad++; $display("FAIL s1_rdata got=%h exp=aaaa0001", rdata1); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL s1_stall got=%b exp=0", mem_stall); end
    @(negedge clk);
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL s1_cnt got=%0d exp=0", cnt); end
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_single_slot2;
    @(negedge clk);
    set_req(0, 0, 0, 0, 1, 0, 32'h08, 0);
    #1;
    total++; if (mem_addr !== 8'h08 || mem_re !== 1'b1) begin bad++; $display("FAIL s2_addr_re got=%h/%b exp=08/1", mem_addr, mem_re); end
    total++; if (rdata2 !== 32'h22 || mem_stall !== 1'b0) begin bad++; $display("FAIL s2_rdata_stall got=%h/%b exp=22/0", rdata2, mem_stall); end
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_dual_load;
    @(negedge clk);
    set_req(1, 0, 32'h04, 0, 1, 0, 32'h08, 0);
    #1;
    total++; if (mem_stall !== 1'b1 || mem_addr !== 8'h04) begin bad++; $display("FAIL dl_c0 got=%b/%h exp=1/04", mem_stall, mem_addr); end
    @(negedge clk);
    total++; if (mem_stall !== 1'b0 || mem_addr !== 8'h08) begin bad++; $display("FAIL dl_c1 got=%b/%h exp=0/08", mem_stall, mem_addr); end
    total++; if (rdata1 !== 32'h11 || rdata2 !== 32'h22) begin bad++; $display("FAIL dl_rdata got=%h/%h exp=11/22", rdata1, rdata2); end
    total++; if (cnt !== 16'd1) begin bad++; $display("FAIL dl_cnt got=%0d exp=1", cnt); end
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_store_then_load;
    @(negedge clk);
    set_req(0, 1, 32'h20, 32'hDEAD, 1, 0, 32'h20, 0);
    #1;
    total++; if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD || mem_stall !== 1'b1) begin bad++; $display("FAIL sl_c0 got=%b/%h/%b exp=1/dead/1", mem_we, mem_wdata, mem_stall); end
    @(negedge clk);
    total++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL sl_c1_re got=%b%b exp=10", mem_re, mem_we); end
    total++; if (rdata2 !== 32'hDEAD) begin bad++; $display("FAIL sl_rdata2 got=%h exp=dead", rdata2); end
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_dual_store;
    int stalls;
    stalls = 0;
    @(negedge clk);
    set_req(0, 1, 32'h30, 32'h1111, 0, 1, 32'h30, 32'h2222);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (mem_stall === 1'b1) stalls++;
      @(negedge clk);
      if (i == 1) set_req(0, 0, 0, 0, 0, 0, 0, 0);
    end
    total++; if (stalls != 1) begin bad++; $display("FAIL ds_stalls got=%0d exp=1", stalls); end
    total++; if (cnt !== 16'd3) begin bad++; $display("FAIL ds_cnt got=%0d exp=3", cnt); end
    set_req(1, 0, 32'h30, 0, 0, 0, 0, 0);
    #1;
    total++; if (rdata1 !== 32'h2222) begin bad++; $display("FAIL ds_mem got=%h exp=2222", rdata1); end
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_then_store;
    @(negedge clk);
    set_req(1, 0, 32'h40, 0, 0, 1, 32'h40, 32'h7777);
    #1;
    total++; if (rdata1 !== 32'h5555) begin bad++; $display("FAIL ls_c0 got=%h exp=5555", rdata1); end
    @(negedge clk);
    total++; if (mem_we !== 1'b1 || mem_wdata !== 32'h7777 || rdata1 !== 32'h5555) begin bad++; $display("FAIL ls_c1 got=%b/%h/%h exp=1/7777/5555", mem_we, mem_wdata, rdata1); end
    @(negedge clk);
    set_req(1, 0, 32'h40, 0, 0, 0, 0, 0);
    #1;
    total++; if (rdata1 !== 32'h7777 || cnt !== 16'd4) begin bad++; $display("FAIL ls_after got=%h/%0d exp=7777/4", rdata1, cnt); end
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_rw_same_slot;
    @(negedge clk);
    set_req(1, 1, 32'h60, 32'h6, 0, 0, 0, 0);
    #1;
    total++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL rw_slot1 got=%b%b%b exp=100", mem_we, mem_re, mem_stall); end
    @(negedge clk);
    set_req(0, 0, 0, 0, 1, 1, 32'h61, 32'h7);
    #1;
    total++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 8'h61) begin bad++; $display("FAIL rw_slot2 got=%b%b/%h exp=10/61", mem_we, mem_re, mem_addr); end
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_serve2_drop;
    @(negedge clk);
    set_req(1, 0, 32'h04, 0, 1, 0, 32'h08, 0);
    @(negedge clk);
    set_req(1, 0, 32'h04, 0, 0, 0, 32'h08, 0);
    #1;
    total++; if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL drop_noacc got=%b%b%b exp=000", mem_we, mem_re, mem_stall); end
    @(negedge clk);
    #1;
    total++; if (mem_stall !== 1'b0 || mem_re !== 1'b1 || cnt !== 16'd5) begin bad++; $display("FAIL drop_next got=%b/%b/%0d exp=0/1/5", mem_stall, mem_re, cnt); end
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_serve2;
    @(negedge clk);
    set_req(1, 0, 32'h04, 0, 1, 0, 32'h08, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (mem_stall !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin bad++; $display("FAIL rmid_quiet got=%b%b%b exp=000", mem_stall, mem_we, mem_re); end
    total++; if (cnt !== 16'd0 || s_cnt !== 2'd0) begin bad++; $display("FAIL rmid_cnt got=%0d/%0d exp=0/0", cnt, s_cnt); end
    total++; if (rdata1 !== 32'hC0DE0000) begin bad++; $display("FAIL rmid_rdata1 got=%h exp=c0de0000", rdata1); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (mem_stall !== 1'b1 || mem_addr !== 8'h04) begin bad++; $display("FAIL rmid_restall got=%b/%h exp=1/04", mem_stall, mem_addr); end
    @(negedge clk);
    total++; if (mem_addr !== 8'h08 || rdata1 !== 32'h11 || cnt !== 16'd1) begin bad++; $display("FAIL rmid_serve2 got=%h/%h/%0d exp=08/11/1", mem_addr, rdata1, cnt); end
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturation;
    logic [1:0]  exp_s [3];
    logic [15:0] exp_c [3];
    exp_s[0] = 2'd2; exp_s[1] = 2'd3; exp_s[2] = 2'd3;
    exp_c[0] = 16'd2; exp_c[1] = 16'd3; exp_c[2] = 16'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_req(1, 0, 32'h04, 0, 1, 0, 32'h08, 0);
      @(negedge clk);
      set_req(0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (s_cnt !== exp_s[i]) begin bad++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, s_cnt, exp_s[i]); end
      total++; if (cnt !== exp_c[i]) begin bad++; $display("FAIL sat_ref%0d got=%0d exp=%0d", i, cnt, exp_c[i]); end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    reset = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset;
    test_single_slot1;
    test_single_slot2;
    test_dual_load;
    test_store_then_load;
    test_dual_store;
    test_load_then_store;
    test_rw_same_slot;
    test_serve2_drop;
    test_reset_mid_serve2;
    test_saturation;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
